rect_rasterizer: RTL

Rectangle-fill pixel generator between the breakout game controller and `vga_adapter`. The game FSM posts solid-colour rectangle requests (paddle, ball, blocks, full-screen clears); this block queues them and streams one pixel per clock onto the adapter's `x`/`y`/`colour`/`plot` inputs. It replaces the per-object draw-counter loops in the game FSM.

---
 rtl/rect_pkg.sv | 32 +++
 rtl/rect_req_fifo.sv | 56 +++++
 rtl/rect_rasterizer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle rasterizer: screen defaults, colours,
// the request record and the scan FSM encoding.
package rect_pkg;

  localparam int DEF_SCREEN_W  = 160;
  localparam int DEF_SCREEN_H  = 120;
  localparam int RECT_COLOUR_W = 3;

  localparam logic [RECT_COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [RECT_COLOUR_W-1:0] GREEN = 3'b010;
  localparam logic [RECT_COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [RECT_COLOUR_W-1:0] WHITE = 3'b111;

  typedef struct packed {
    logic [7:0]               x;
    logic [7:0]               y;
    logic [7:0]               w;
    logic [7:0]               h;
    logic [RECT_COLOUR_W-1:0] colour;
  } rect_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } rect_state_t;

  // A rectangle with no width or no height covers no pixels.
  function automatic logic rect_is_empty(input logic [7:0] w, input logic [7:0] h);
    return (w == 8'd0) || (h == 8'd0);
  endfunction

endpackage

// File: rtl/rect_req_fifo.sv
// Synchronous request FIFO with count-based full/empty; head entry is always
// visible on o_data while o_empty is low.
module rect_req_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 35
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rect_rasterizer.sv
// Queued solid-rectangle pixel generator feeding vga_adapter, one pixel per clock.
// Optional macro RECT_CLIP_EN suppresses pix_plot for pixels outside the screen.
module rect_rasterizer
  import rect_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int COLOUR_W   = RECT_COLOUR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_x,
  input  logic [7:0]          req_y,
  input  logic [7:0]          req_w,
  input  logic [7:0]          req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic [7:0]          pix_x,
  output logic [7:0]          pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_plot,
  output logic                busy,
  output logic                done
);

  localparam int DW = 32 + COLOUR_W;

  if ((SCREEN_W > 256) || (SCREEN_H > 256) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("rect_rasterizer: unsupported parameter values");
  end

  logic                w_push, w_pop, w_full, w_empty, w_load, w_last, w_row_end;
  logic [DW-1:0]       w_head;
  logic [7:0]          w_hx, w_hy, w_hw, w_hh;
  logic [COLOUR_W-1:0] w_hcol;

  rect_state_t         r_state, w_state_next;
  logic [7:0]          r_x0, r_y0, r_w, r_h, r_cx, r_cy;
  logic [7:0]          w_x0_next, w_y0_next, w_w_next, w_h_next, w_cx_next, w_cy_next;
  logic [COLOUR_W-1:0] r_col, w_col_next;
  logic                r_done_empty, w_done_empty_next;

  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready;
  assign {w_hx, w_hy, w_hw, w_hh, w_hcol} = w_head;

  rect_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  ({req_x, req_y, req_w, req_h, req_colour}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_row_end = (r_cx == r_w - 8'd1);
  assign w_last    = (r_state == ST_DRAW) && w_row_end && (r_cy == r_h - 8'd1);
  // A new request is taken whenever idle, or on the last pixel so rectangles chain without a bubble.
  assign w_load    = !w_empty && ((r_state == ST_IDLE) || w_last);
  assign w_pop     = w_load;

  // Next-state and counter logic for the scan FSM.
  always_comb begin
    w_state_next      = r_state;
    w_x0_next         = r_x0;
    w_y0_next         = r_y0;
    w_w_next          = r_w;
    w_h_next          = r_h;
    w_col_next        = r_col;
    w_cx_next         = r_cx;
    w_cy_next         = r_cy;
    w_done_empty_next = 1'b0;
    if (w_load) begin
      w_x0_next  = w_hx;
      w_y0_next  = w_hy;
      w_w_next   = w_hw;
      w_h_next   = w_hh;
      w_col_next = w_hcol;
      w_cx_next  = 8'd0;
      w_cy_next  = 8'd0;
      if (rect_is_empty(w_hw, w_hh)) begin
        w_state_next      = ST_IDLE;
        w_done_empty_next = 1'b1;
      end else begin
        w_state_next = ST_DRAW;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_DRAW: begin
          if (w_last) begin
            w_state_next = ST_IDLE;
            w_cx_next    = 8'd0;
            w_cy_next    = 8'd0;
          end else if (w_row_end) begin
            w_cx_next = 8'd0;
            w_cy_next = r_cy + 8'd1;
          end else begin
            w_cx_next = r_cx + 8'd1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cx_next    = 8'd0;
          w_cy_next    = 8'd0;
        end
      endcase
    end
  end

  // Scan state and working registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_x0         <= 8'd0;
      r_y0         <= 8'd0;
      r_w          <= 8'd0;
      r_h          <= 8'd0;
      r_col        <= '0;
      r_cx         <= 8'd0;
      r_cy         <= 8'd0;
      r_done_empty <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_x0         <= w_x0_next;
      r_y0         <= w_y0_next;
      r_w          <= w_w_next;
      r_h          <= w_h_next;
      r_col        <= w_col_next;
      r_cx         <= w_cx_next;
      r_cy         <= w_cy_next;
      r_done_empty <= w_done_empty_next;
    end
  end

  assign pix_colour = r_col;
  assign done       = r_done_empty || w_last;
  assign busy       = (r_state == ST_DRAW) || !w_empty;

`ifdef RECT_CLIP_EN
  logic [8:0] w_sum_x, w_sum_y;
  assign w_sum_x  = {1'b0, r_x0} + {1'b0, r_cx};
  assign w_sum_y  = {1'b0, r_y0} + {1'b0, r_cy};
  assign pix_x    = w_sum_x[7:0];
  assign pix_y    = w_sum_y[7:0];
  // Off-screen pixels still take their cycle; only the strobe is suppressed.
  assign pix_plot = (r_state == ST_DRAW) && (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 9'(SCREEN_H));
`else
  assign pix_x    = r_x0 + r_cx;
  assign pix_y    = r_y0 + r_cy;
  assign pix_plot = (r_state == ST_DRAW);
`endif

endmodule
